// File: rtl/uaddr_gen.sv
// Micro-address generator for the microcode ROM: opcode latch, micro-step
// counter, conditional-jump index remap and interrupt pseudo-opcode entry.
//
// Ports:
//   Q          clock; all state changes on its rising edge
//   Reset      asynchronous active-high reset
//   dataIn     opcode byte, sampled only on a fetch edge
//   fetch      end-of-instruction from the microword; load next opcode
//   jumpOpe    conditional-jump request from the microword
//   noJump     condition-false flag, qualified by jumpOpe
//   stall      bus wait; freezes everything except the IRQ synchronizer
//   nIRQ       asynchronous active-low level interrupt request
//   irqMask    1 = interrupts masked
//   uromAddr   {opeIdx, step} micro-ROM address
//   opeCode    latched opcode
//   step       current micro-step
//   IRQH       1 while the interrupt routine runs
//   fetchCycle 1 during step 0 of a freshly fetched instruction
//   stepOvf    sticky: step counter reached its maximum without a fetch

module uaddr_gen #(
   parameter int unsigned STEP_W   = 2,
   parameter logic [7:0]  RESET_OP = 8'hE0,
   parameter logic [7:0]  IRQ_OP   = 8'hE1
) (
   input  logic              Q,
   input  logic              Reset,
   input  logic [7:0]        dataIn,
   input  logic              fetch,
   input  logic              jumpOpe,
   input  logic              noJump,
   input  logic              stall,
   input  logic              nIRQ,
   input  logic              irqMask,
   output logic [8+STEP_W-1:0] uromAddr,
   output logic [7:0]        opeCode,
   output logic [STEP_W-1:0] step,
   output logic              IRQH,
   output logic              fetchCycle,
   output logic              stepOvf
);

   localparam logic [STEP_W-1:0] STEP_MAX = '1;

   logic [7:0]        ope_code_q, ope_code_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              jcc_q, jcc_d;
   logic              jnj_q, jnj_d;
   logic              irqh_q, irqh_d;
   logic              fetch_cycle_q, fetch_cycle_d;
   logic              step_ovf_q, step_ovf_d;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;

   logic              irq_pend;
   logic [7:0]        ope_idx;

   // Two-flop synchronizer; runs even during stall so a request is
   // already settled when the bus wait ends.
   always_comb begin
      sync1_d = nIRQ;
      sync2_d = sync1_q;
   end

   assign irq_pend = ~sync2_q & ~irqMask;

   always_comb begin
      ope_code_d    = ope_code_q;
      step_d        = step_q;
      jcc_d         = jcc_q;
      jnj_d         = jnj_q;
      irqh_d        = irqh_q;
      fetch_cycle_d = fetch_cycle_q;
      step_ovf_d    = step_ovf_q;

      if (stall) begin
         // hold everything
      end else if (fetch) begin
         // The opcode byte is not consumed when the interrupt is taken;
         // it is refetched after the interrupt routine returns.
         ope_code_d    = irq_pend ? IRQ_OP : dataIn;
         irqh_d        = irq_pend;
         step_d        = '0;
         jcc_d         = 1'b0;
         fetch_cycle_d = 1'b1;
      end else if (jumpOpe) begin
         jcc_d         = 1'b1;
         jnj_d         = noJump;
         step_d        = '0;
         fetch_cycle_d = 1'b0;
      end else if (step_q != STEP_MAX) begin
         step_d        = step_q + STEP_W'(1);
         fetch_cycle_d = 1'b0;
      end else begin
         // Saturate rather than wrap so a runaway microroutine parks on
         // its last word and is flagged.
         step_ovf_d    = 1'b1;
         fetch_cycle_d = 1'b0;
      end
   end

   always_ff @(posedge Q or posedge Reset) begin
      if (Reset) begin
         ope_code_q    <= RESET_OP;
         step_q        <= '0;
         jcc_q         <= 1'b0;
         jnj_q         <= 1'b0;
         irqh_q        <= 1'b0;
         fetch_cycle_q <= 1'b1;
         step_ovf_q    <= 1'b0;
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
      end else begin
         ope_code_q    <= ope_code_d;
         step_q        <= step_d;
         jcc_q         <= jcc_d;
         jnj_q         <= jnj_d;
         irqh_q        <= irqh_d;
         fetch_cycle_q <= fetch_cycle_d;
         step_ovf_q    <= step_ovf_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
      end
   end

   // Jump remap keeps the opcode's high nibble (its instruction group)
   // and selects the taken/not-taken continuation slot xxx111j.
   always_comb begin
      if (jcc_q) ope_idx = {ope_code_q[7:4], 3'b111, jnj_q};
      else       ope_idx = ope_code_q;
   end

   assign uromAddr   = {ope_idx, step_q};
   assign opeCode    = ope_code_q;
   assign step       = step_q;
   assign IRQH       = irqh_q;
   assign fetchCycle = fetch_cycle_q;
   assign stepOvf    = step_ovf_q;

endmodule

// File: tb/tb_uaddr_gen.sv
// Scoreboarded bench for uaddr_gen: directed scenarios then random traffic,
// checked against a behavioural model of the micro-address rules.

module tb_uaddr_gen;

   logic       Q = 1'b0;
   logic       Reset;
   logic [7:0] dataIn;
   logic       fetch, jumpOpe, noJump, stall, nIRQ, irqMask;
   logic [9:0] uromAddr;
   logic [7:0] opeCode;
   logic [1:0] step;
   logic       IRQH, fetchCycle, stepOvf;

   uaddr_gen dut (
      .Q(Q), .Reset(Reset), .dataIn(dataIn), .fetch(fetch),
      .jumpOpe(jumpOpe), .noJump(noJump), .stall(stall),
      .nIRQ(nIRQ), .irqMask(irqMask), .uromAddr(uromAddr),
      .opeCode(opeCode), .step(step), .IRQH(IRQH),
      .fetchCycle(fetchCycle), .stepOvf(stepOvf)
   );

   always #5 Q = ~Q;

   typedef struct packed {
      logic [9:0] a;
      logic [7:0] op;
      logic [1:0] st;
      logic       ih;
      logic       fc;
      logic       ov;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // model state
   int   m_op, m_step, m_jcc, m_jnj, m_irqh, m_fc, m_ovf;
   int   nirq_hist[2];   // [0] = last edge sample, [1] = two edges ago

   function automatic void m_reset();
      m_op = 'hE0; m_step = 0; m_jcc = 0; m_jnj = 0;
      m_irqh = 0; m_fc = 1; m_ovf = 0;
      nirq_hist[0] = 1; nirq_hist[1] = 1;
   endfunction

   function automatic exp_t cur_exp();
      exp_t e;
      int idx;
      idx = m_jcc ? ((m_op & 'hF0) + 'h0E + m_jnj) : m_op;
      e.a  = 10'(idx * 4 + m_step);
      e.op = 8'(m_op);
      e.st = 2'(m_step);
      e.ih = 1'(m_irqh);
      e.fc = 1'(m_fc);
      e.ov = 1'(m_ovf);
      return e;
   endfunction

   function automatic void model_edge();
      bit pend;
      pend = (nirq_hist[1] == 0) && !irqMask;
      if (stall) begin
      end else if (fetch) begin
         m_op   = pend ? 'hE1 : int'(dataIn);
         m_irqh = pend;
         m_step = 0; m_jcc = 0; m_fc = 1;
      end else if (jumpOpe) begin
         m_jcc = 1; m_jnj = noJump; m_step = 0; m_fc = 0;
      end else if (m_step < 3) begin
         m_step++; m_fc = 0;
      end else begin
         m_ovf = 1; m_fc = 0;
      end
      nirq_hist[1] = nirq_hist[0];
      nirq_hist[0] = nIRQ;
   endfunction

   task automatic cmp(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_reset();
      cmp("rst_addr", uromAddr, 'h380);
      cmp("rst_step", step, 0);
      cmp("rst_irqh", IRQH, 0);
      cmp("rst_fc", fetchCycle, 1);
      cmp("rst_ovf", stepOvf, 0);
   endtask

   task automatic cyc(input logic f, input logic [7:0] d, input logic j,
                      input logic nj, input logic st, input logic ni,
                      input logic mk);
      @(negedge Q);
      fetch = f; dataIn = d; jumpOpe = j; noJump = nj;
      stall = st; nIRQ = ni; irqMask = mk;
      @(posedge Q);
      model_edge();
      sb.push_back(cur_exp());
      #2;
   endtask

   task automatic plain(input int n);
      for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 1, 0);
   endtask

   task automatic rst_pulse();
      Reset = 1'b1;
      #1;
      m_reset();
      chk_reset();
      Reset = 1'b0;
      #1;
   endtask

   // monitor: output is presented every clock
   initial begin
      exp_t e, g;
      forever begin
         @(posedge Q);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            g = {uromAddr, opeCode, step, IRQH, fetchCycle, stepOvf};
            n_vec++;
            if (g !== e) begin
               n_bad++;
               $display("FAIL sb: got a=%h op=%h st=%0d ih=%b fc=%b ov=%b expected a=%h op=%h st=%0d ih=%b fc=%b ov=%b at %0t",
                        g.a, g.op, g.st, g.ih, g.fc, g.ov,
                        e.a, e.op, e.st, e.ih, e.fc, e.ov, $time);
            end
         end
      end
   end

   initial begin
      logic ni_lvl;
      Reset = 1'b1; dataIn = 0; fetch = 0; jumpOpe = 0; noJump = 0;
      stall = 0; nIRQ = 1; irqMask = 0;
      m_reset();
      #7;
      chk_reset();
      Reset = 1'b0;

      // sequential stepping and saturation
      cyc(1, 8'h3A, 0, 0, 0, 1, 0);
      cmp("fetch_3A", uromAddr, 'h0E8);
      plain(3);
      cmp("step3", uromAddr, 'h0EB);
      plain(1);
      cmp("sat_addr", uromAddr, 'h0EB);
      cmp("sat_ovf", stepOvf, 1);

      // async reset mid-instruction
      cyc(1, 8'h3A, 0, 0, 0, 1, 0);
      plain(2);
      cmp("mid_step", step, 2);
      rst_pulse();

      // conditional jump remap
      cyc(1, 8'h25, 0, 0, 0, 1, 0);
      plain(1);
      cyc(0, 8'h00, 1, 1, 0, 1, 0);
      cmp("jump_addr", uromAddr, 'h0BC);
      cyc(1, 8'h10, 0, 0, 0, 1, 0);
      cmp("jump_clr", uromAddr, 'h040);

      // interrupt entry, then masked request
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 0, 0, 0);
      cyc(1, 8'h55, 0, 0, 0, 0, 0);
      cmp("irq_addr", uromAddr, 'h384);
      cmp("irq_h", IRQH, 1);
      plain(3);
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 0, 0, 0, 1);
      cyc(1, 8'h55, 0, 0, 0, 0, 1);
      cmp("mask_op", opeCode, 'h55);
      cmp("mask_h", IRQH, 0);
      plain(2);

      // stall freezes, fetch lands on first edge after release
      for (int i = 0; i < 3; i++) cyc(1, 8'h77, 1, 0, 1, 1, 0);
      cmp("stall_addr", uromAddr, 'h156);
      cyc(1, 8'h77, 1, 0, 0, 1, 0);
      cmp("unstall", uromAddr, 'h1DC);

      // fetch wins over jump
      cyc(1, 8'h80, 1, 1, 0, 1, 0);
      cmp("fetch_jump", uromAddr, 'h200);

      // random traffic
      ni_lvl = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) ni_lvl = ~ni_lvl;
         cyc($urandom_range(0, 3) == 0, 8'($urandom),
             $urandom_range(0, 4) == 0, 1'($urandom),
             $urandom_range(0, 6) == 0, ni_lvl,
             $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 150) == 0) rst_pulse();
      end

      @(posedge Q);
      #3;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
